// File: rtl/keypad_code_entry_if.sv
// Keypad-side bundle: car/key/gate inputs in, assembled password and status out.
// The master drives keys and sees the status; the slave is the code-entry block.
interface keypad_code_entry_if;
  logic       car;
  logic       key_vld;
  logic [3:0] key_code;
  logic       gate;
  logic [7:0] pswd;
  logic       pswd_vld;
  logic [1:0] digit_cnt;
  logic       locked;
  logic [1:0] fail_cnt;
  logic       beep;

  modport master (
    output car, key_vld, key_code, gate,
    input  pswd, pswd_vld, digit_cnt, locked, fail_cnt, beep
  );

  modport slave (
    input  car, key_vld, key_code, gate,
    output pswd, pswd_vld, digit_cnt, locked, fail_cnt, beep
  );
endinterface

// File: rtl/keypad_code_entry.sv
// Assembles keypad digits into an 8-bit password for the gate controller, counts failed
// attempts from the gate response and enforces a timed lockout. Key beep: KEYPAD_BEEP_EN.
module keypad_code_entry #(
  parameter int MAX_DIGITS  = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int RESP_CYC    = 16,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYC    = 5000
) (
  input  logic                clk,
  input  logic                rst_n,
  keypad_code_entry_if.slave  bus
);

  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(RESP_CYC + 1);
  localparam int LW = $clog2(LOCK_CYC + 1);

  typedef enum logic [2:0] {IDLE, ENTRY, PRESENT, WAIT_GATE, DONE, LOCKED} state_t;

  state_t        state, state_nx;
  logic [7:0]    acc, acc_nx;
  logic          ovf, ovf_nx;
  logic [1:0]    dcnt, dcnt_nx;
  logic [7:0]    pswd_q, pswd_nx;
  logic [1:0]    fcnt, fcnt_nx;
  logic [IW-1:0] idle_tmr, idle_nx;
  logic [RW-1:0] resp_tmr, resp_nx;
  logic [LW-1:0] lock_tmr, lock_nx;
  logic [9:0]    prod;
  logic          fail;
  logic          is_digit;
  logic          room;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= 8'd0;
      ovf      <= 1'b0;
      dcnt     <= 2'd0;
      pswd_q   <= 8'd0;
      fcnt     <= 2'd0;
      idle_tmr <= '0;
      resp_tmr <= '0;
      lock_tmr <= '0;
    end else begin
      state    <= state_nx;
      acc      <= acc_nx;
      ovf      <= ovf_nx;
      dcnt     <= dcnt_nx;
      pswd_q   <= pswd_nx;
      fcnt     <= fcnt_nx;
      idle_tmr <= idle_nx;
      resp_tmr <= resp_nx;
      lock_tmr <= lock_nx;
    end
  end

  assign is_digit = (bus.key_code <= 4'd9);
  assign room     = (int'(dcnt) < MAX_DIGITS);

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    ovf_nx   = ovf;
    dcnt_nx  = dcnt;
    pswd_nx  = pswd_q;
    fcnt_nx  = fcnt;
    idle_nx  = idle_tmr;
    resp_nx  = resp_tmr;
    lock_nx  = lock_tmr;
    fail     = 1'b0;
    prod     = {2'b00, acc} * 10'd10 + {6'b000000, bus.key_code};

    case (state)
      IDLE: begin
        if (bus.car) begin
          state_nx = ENTRY;
          acc_nx   = 8'd0;
          dcnt_nx  = 2'd0;
          ovf_nx   = 1'b0;
          idle_nx  = '0;
        end
      end
      ENTRY: begin
        if (!bus.car) begin
          state_nx = IDLE;
          pswd_nx  = 8'd0;
          dcnt_nx  = 2'd0;
        end else if (bus.key_vld) begin
          idle_nx = '0;
          if (is_digit) begin
            if (room) begin
              acc_nx  = prod[7:0];
              ovf_nx  = ovf | (prod > 10'd255);
              dcnt_nx = dcnt + 2'd1;
            end
          end else if (bus.key_code == 4'hA) begin
            acc_nx  = 8'd0;
            dcnt_nx = 2'd0;
            ovf_nx  = 1'b0;
          end else if (bus.key_code == 4'hB && dcnt != 2'd0) begin
            if (ovf) begin
              fail = 1'b1;
            end else begin
              pswd_nx  = acc;
              state_nx = PRESENT;
            end
          end
        end else if (dcnt != 2'd0) begin
          // A stale partial entry is silently dropped; it does not count as an attempt.
          if (idle_tmr == IW'(TIMEOUT_CYC - 1)) begin
            acc_nx  = 8'd0;
            dcnt_nx = 2'd0;
            ovf_nx  = 1'b0;
            idle_nx = '0;
          end else begin
            idle_nx = idle_tmr + 1'b1;
          end
        end
      end
      PRESENT: begin
        if (!bus.car) begin
          state_nx = IDLE;
          pswd_nx  = 8'd0;
          dcnt_nx  = 2'd0;
        end else begin
          state_nx = WAIT_GATE;
          resp_nx  = '0;
        end
      end
      WAIT_GATE: begin
        if (!bus.car) begin
          state_nx = IDLE;
          pswd_nx  = 8'd0;
          dcnt_nx  = 2'd0;
        end else if (bus.gate) begin
          fcnt_nx  = 2'd0;
          state_nx = DONE;
        end else if (resp_tmr == RW'(RESP_CYC - 1)) begin
          fail    = 1'b1;
          pswd_nx = 8'd0;
        end else begin
          resp_nx = resp_tmr + 1'b1;
        end
      end
      DONE: begin
        if (!bus.car) begin
          state_nx = IDLE;
          pswd_nx  = 8'd0;
        end
      end
      LOCKED: begin
        if (lock_tmr == LW'(LOCK_CYC - 1)) begin
          fcnt_nx  = 2'd0;
          state_nx = bus.car ? ENTRY : IDLE;
          acc_nx   = 8'd0;
          dcnt_nx  = 2'd0;
          ovf_nx   = 1'b0;
          idle_nx  = '0;
        end else begin
          lock_nx = lock_tmr + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (fail) begin
      fcnt_nx = fcnt + 2'd1;
      acc_nx  = 8'd0;
      dcnt_nx = 2'd0;
      ovf_nx  = 1'b0;
      idle_nx = '0;
      if (int'(fcnt) + 1 == MAX_FAIL) begin
        state_nx = LOCKED;
        lock_nx  = '0;
      end else begin
        state_nx = ENTRY;
      end
    end
  end

  assign bus.pswd      = pswd_q;
  assign bus.pswd_vld  = (state == PRESENT);
  assign bus.digit_cnt = dcnt;
  assign bus.locked    = (state == LOCKED);
  assign bus.fail_cnt  = fcnt;

`ifdef KEYPAD_BEEP_EN
  logic [2:0] beep_cnt;
  logic       key_ok;

  // Keys that change the entry: accepted digit, clear, or an enter that presents a code.
  assign key_ok = (state == ENTRY) && bus.car && bus.key_vld &&
                  ((is_digit && room) || (bus.key_code == 4'hA) ||
                   (bus.key_code == 4'hB && dcnt != 2'd0 && !ovf));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      beep_cnt <= 3'd0;
    else if (key_ok)
      beep_cnt <= 3'd4;
    else if (beep_cnt != 3'd0)
      beep_cnt <= beep_cnt - 3'd1;
  end

  assign bus.beep = (beep_cnt != 3'd0) || (state == LOCKED);
`else
  assign bus.beep = 1'b0;
`endif

endmodule
